// File: rtl/prio_mixer_pkg.sv
// Shared constants, the running-candidate record and the layer transparency rule
// for the priority mixer.
package prio_mixer_pkg;

  localparam int MAX_PW   = 8;
  localparam int MAX_COLW = 24;

  localparam logic [4:0] ADDR_BANK0  = 5'd8;
  localparam logic [4:0] ADDR_TMODE  = 5'd16;
  localparam logic [4:0] ADDR_PSEL   = 5'd17;
  localparam logic [4:0] ADDR_BRTH   = 5'd18;
  localparam logic [4:0] ADDR_ENABLE = 5'd19;
  localparam logic [4:0] ADDR_SHTH1  = 5'd20;
  localparam logic [4:0] ADDR_SHTH2  = 5'd21;
  localparam logic [4:0] ADDR_SHTH3  = 5'd22;

  // Fields are sized for the widest supported layer; narrower values are zero-extended.
  typedef struct packed {
    logic                opaque;
    logic [MAX_PW-1:0]   prio;
    logic [MAX_COLW-1:0] color;
  } cand_t;

  localparam int CAND_W = $bits(cand_t);

  function automatic logic layer_opaque(input logic [7:0] ci_low, input logic tmode,
                                        input logic enable);
    return enable && (tmode ? (ci_low != 8'd0) : (ci_low[3:0] != 4'd0));
  endfunction

endpackage

// File: rtl/prio_mixer_stage.sv
// One chain stage: merge a single layer into the running candidate and register it.
module prio_mixer_stage
  import prio_mixer_pkg::*;
#(
  parameter int PW = 6,
  parameter int CW = 9,
  parameter int BW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CAND_W-1:0] cand_in,
  input  logic [CW-1:0]     ci,
  input  logic [PW-1:0]     pr,
  input  logic [PW-1:0]     prio_reg,
  input  logic [BW-1:0]     bank,
  input  logic              tmode,
  input  logic              psel,
  input  logic              enable,
  output logic [CAND_W-1:0] cand_out
);

  cand_t             prev;
  cand_t             merged;
  logic              opaque;
  logic [MAX_PW-1:0] eff_prio;

  assign prev = cand_t'(cand_in);

  // Strict less-than keeps ties with the earlier (lower-index) layer.
  always_comb begin
    opaque   = layer_opaque(ci[7:0], tmode, enable);
    eff_prio = MAX_PW'(psel ? prio_reg : pr);
    merged   = prev;
    if (opaque && (!prev.opaque || eff_prio < prev.prio)) begin
      merged.opaque = 1'b1;
      merged.prio   = eff_prio;
      merged.color  = MAX_COLW'({bank, ci});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cand_out <= '0;
    else        cand_out <= merged;
  end

endmodule

// File: rtl/prio_mixer_n.sv
// N-layer priority mixer: register file, layer-0 seed, linear merge chain with
// per-layer input delays, and the output stage (brightness and shadow gating).
module prio_mixer_n
  import prio_mixer_pkg::*;
#(
  parameter int NLAYER = 5,
  parameter int CW     = 9,
  parameter int PW     = 6,
  parameter int BW     = 2
) (
  input  logic                 CLK,
  input  logic                 nRESET,
  input  logic                 nCS,
  input  logic [4:0]           ADDR,
  input  logic [7:0]           DIN,
  input  logic [NLAYER*PW-1:0] PR,
  input  logic [NLAYER*CW-1:0] CI,
  input  logic [1:0]           SDI,
  output logic [BW+CW-1:0]     CO,
  output logic                 NCOL,
  output logic                 BRIT,
  output logic [1:0]           SDO
);

  logic [PW-1:0]     prio_r [NLAYER];
  logic [BW-1:0]     bank_r [NLAYER];
  logic [NLAYER-1:0] tmode_r;
  logic [NLAYER-1:0] psel_r;
  logic [NLAYER-1:0] enable_r;
  logic [PW-1:0]     brth_r;
  logic [PW-1:0]     shth_r [3];

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < NLAYER; i++) begin
        prio_r[i] <= '1;
        bank_r[i] <= '0;
      end
      tmode_r  <= '0;
      psel_r   <= '0;
      enable_r <= '1;
      brth_r   <= '1;
      for (int j = 0; j < 3; j++) shth_r[j] <= '1;
    end else if (!nCS) begin
      for (int i = 0; i < NLAYER; i++) begin
        if (ADDR == 5'(i))              prio_r[i] <= DIN[PW-1:0];
        if (ADDR == ADDR_BANK0 + 5'(i)) bank_r[i] <= DIN[BW-1:0];
      end
      case (ADDR)
        ADDR_TMODE:  tmode_r   <= DIN[NLAYER-1:0];
        ADDR_PSEL:   psel_r    <= DIN[NLAYER-1:0];
        ADDR_BRTH:   brth_r    <= DIN[PW-1:0];
        ADDR_ENABLE: enable_r  <= DIN[NLAYER-1:0];
        ADDR_SHTH1:  shth_r[0] <= DIN[PW-1:0];
        ADDR_SHTH2:  shth_r[1] <= DIN[PW-1:0];
        ADDR_SHTH3:  shth_r[2] <= DIN[PW-1:0];
        default: ;
      endcase
    end
  end

  logic [CAND_W-1:0] chain [NLAYER];
  cand_t             seed_d;
  logic [CAND_W-1:0] seed_q;

  always_comb begin
    seed_d = '0;
    if (layer_opaque(CI[7:0], tmode_r[0], enable_r[0])) begin
      seed_d.opaque = 1'b1;
      seed_d.prio   = MAX_PW'(psel_r[0] ? prio_r[0] : PR[PW-1:0]);
      seed_d.color  = MAX_COLW'({bank_r[0], CI[CW-1:0]});
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) seed_q <= '0;
    else         seed_q <= seed_d;
  end

  assign chain[0] = seed_q;

  // Layer k is delayed k cycles so it meets the candidate of the same pixel.
  for (genvar k = 1; k < NLAYER; k++) begin : g_layer
    logic [CW-1:0] ci_d [k];
    logic [PW-1:0] pr_d [k];

    always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
        for (int j = 0; j < k; j++) begin
          ci_d[j] <= '0;
          pr_d[j] <= '0;
        end
      end else begin
        ci_d[0] <= CI[k*CW +: CW];
        pr_d[0] <= PR[k*PW +: PW];
        for (int j = 1; j < k; j++) begin
          ci_d[j] <= ci_d[j-1];
          pr_d[j] <= pr_d[j-1];
        end
      end
    end

    prio_mixer_stage #(.PW(PW), .CW(CW), .BW(BW)) u_stage (
      .clk      (CLK),
      .rst_n    (nRESET),
      .cand_in  (chain[k-1]),
      .ci       (ci_d[k-1]),
      .pr       (pr_d[k-1]),
      .prio_reg (prio_r[k]),
      .bank     (bank_r[k]),
      .tmode    (tmode_r[k]),
      .psel     (psel_r[k]),
      .enable   (enable_r[k]),
      .cand_out (chain[k])
    );
  end

  logic [1:0] sdi_d [NLAYER];

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int j = 0; j < NLAYER; j++) sdi_d[j] <= '0;
    end else begin
      sdi_d[0] <= SDI;
      for (int j = 1; j < NLAYER; j++) sdi_d[j] <= sdi_d[j-1];
    end
  end

  cand_t             last;
  logic [1:0]        sdi_out;
  logic [MAX_PW-1:0] win_prio;
  logic [MAX_PW-1:0] thr;

  assign last    = cand_t'(chain[NLAYER-1]);
  assign sdi_out = sdi_d[NLAYER-1];

  always_comb begin
    win_prio = last.opaque ? last.prio : MAX_PW'({PW{1'b1}});
    thr      = MAX_PW'({PW{1'b1}});
    case (sdi_out)
      2'd1:    thr = MAX_PW'(shth_r[0]);
      2'd2:    thr = MAX_PW'(shth_r[1]);
      2'd3:    thr = MAX_PW'(shth_r[2]);
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      CO   <= '0;
      NCOL <= 1'b1;
      BRIT <= 1'b0;
      SDO  <= 2'b00;
    end else begin
      CO   <= last.opaque ? last.color[BW+CW-1:0] : '0;
      NCOL <= !last.opaque;
      BRIT <= last.opaque && (win_prio < MAX_PW'(brth_r));
      SDO  <= (win_prio < thr) ? sdi_out : 2'b00;
    end
  end

endmodule

// File: tb/tb_prio_mixer_n.sv
// Scoreboard bench for prio_mixer_n: driver pushes model results tagged with the
// sampling cycle, the monitor pops and compares once the pipeline latency elapses.
module tb_prio_mixer_n;

  localparam int NL = 5;
  localparam int CW = 9;
  localparam int PW = 6;
  localparam int BW = 2;
  localparam int EW = 16;

  logic              CLK = 1'b0;
  logic              nRESET;
  logic              nCS;
  logic [4:0]        ADDR;
  logic [7:0]        DIN;
  logic [NL*PW-1:0]  PR;
  logic [NL*CW-1:0]  CI;
  logic [1:0]        SDI;
  logic [BW+CW-1:0]  CO;
  logic              NCOL;
  logic              BRIT;
  logic [1:0]        SDO;

  prio_mixer_n #(.NLAYER(NL), .CW(CW), .PW(PW), .BW(BW)) dut (
    .CLK(CLK), .nRESET(nRESET), .nCS(nCS), .ADDR(ADDR), .DIN(DIN),
    .PR(PR), .CI(CI), .SDI(SDI), .CO(CO), .NCOL(NCOL), .BRIT(BRIT), .SDO(SDO)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  int            tag_q[$];

  // reference model state
  logic [PW-1:0] m_prio [NL];
  logic [BW-1:0] m_bank [NL];
  logic [NL-1:0] m_tmode, m_psel, m_enable;
  logic [PW-1:0] m_brth;
  logic [PW-1:0] m_shth [4];

  logic [CW-1:0] px_ci [NL];
  logic [PW-1:0] px_pr [NL];
  logic [1:0]    px_sdi;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_prio[i] = '1;
      m_bank[i] = '0;
    end
    m_tmode = '0; m_psel = '0; m_enable = '1; m_brth = '1;
    for (int i = 0; i < 4; i++) m_shth[i] = '1;
  endtask

  task automatic model_write(input int addr, input logic [7:0] data);
    for (int i = 0; i < NL; i++) begin
      if (addr == i)     m_prio[i] = data[PW-1:0];
      if (addr == 8 + i) m_bank[i] = data[BW-1:0];
    end
    case (addr)
      16: m_tmode  = data[NL-1:0];
      17: m_psel   = data[NL-1:0];
      18: m_brth   = data[PW-1:0];
      19: m_enable = data[NL-1:0];
      20, 21, 22: m_shth[addr-19] = data[PW-1:0];
      default: ;
    endcase
  endtask

  // Lowest effective priority among opaque layers; first found wins ties.
  function automatic logic [EW-1:0] model_exp();
    int               w;
    int               best;
    int               p;
    int               wp;
    int               thr;
    bit               op;
    logic [BW+CW-1:0] co;
    logic [1:0]       sdo;
    w = -1; best = 0;
    for (int i = 0; i < NL; i++) begin
      if (m_tmode[i]) op = m_enable[i] && (px_ci[i] % 256 != 0);
      else            op = m_enable[i] && (px_ci[i] % 16 != 0);
      p = m_psel[i] ? int'(m_prio[i]) : int'(px_pr[i]);
      if (op && (w < 0 || p < best)) begin
        w = i; best = p;
      end
    end
    wp  = (w < 0) ? 63 : best;
    co  = (w < 0) ? '0 : {m_bank[w], px_ci[w]};
    thr = (px_sdi == 0) ? 63 : int'(m_shth[px_sdi]);
    sdo = (wp < thr) ? px_sdi : 2'b00;
    return {1'b1, co, (w < 0), (w >= 0 && wp < int'(m_brth)), sdo};
  endfunction

  // driver tasks
  task automatic clear_px();
    for (int i = 0; i < NL; i++) begin
      px_ci[i] = '0;
      px_pr[i] = '0;
    end
    px_sdi = 2'b00;
  endtask

  task automatic rand_px();
    for (int i = 0; i < NL; i++) begin
      case ($urandom_range(0, 3))
        0:       px_ci[i] = '0;
        1:       px_ci[i] = CW'($urandom_range(0, 31) * 16);
        default: px_ci[i] = CW'($urandom);
      endcase
      px_pr[i] = ($urandom_range(0, 1) == 1) ? PW'($urandom_range(0, 7)) : PW'($urandom);
    end
    px_sdi = 2'($urandom);
  endtask

  task automatic send(input bit chk);
    logic [EW-1:0] e;
    for (int i = 0; i < NL; i++) begin
      CI[i*CW +: CW] = px_ci[i];
      PR[i*PW +: PW] = px_pr[i];
    end
    SDI = px_sdi;
    e = model_exp();
    e[EW-1] = chk;
    exp_q.push_back(e);
    tag_q.push_back(cyc + 1);
    @(posedge CLK);
    #1;
    nCS = 1'b1;
  endtask

  // Pixels in flight across a write are sent unchecked.
  task automatic write_reg(input int addr, input logic [7:0] data);
    for (int k = 0; k < NL; k++) begin
      if (k == NL - 1) begin
        nCS = 1'b0; ADDR = 5'(addr); DIN = data;
      end
      send(1'b0);
    end
    model_write(addr, data);
  endtask

  task automatic chk_reset_outs(input string name);
    checks++;
    if (CO !== '0 || NCOL !== 1'b1 || BRIT !== 1'b0 || SDO !== 2'b00) begin
      failures++;
      $display("FAIL %s got co=%h ncol=%b brit=%b sdo=%0d want co=0 ncol=1 brit=0 sdo=0",
               name, CO, NCOL, BRIT, SDO);
    end
  endtask

  // scoreboard monitor
  logic [EW-1:0] mon_e;
  int            mon_tag;
  always @(negedge CLK) begin
    if (nRESET) begin
      if (tag_q.size() != 0 && tag_q[0] == cyc - NL) begin
        mon_e   = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        if (mon_e[EW-1]) begin
          checks++;
          if ({CO, NCOL, BRIT, SDO} !== mon_e[EW-2:0]) begin
            failures++;
            $display("FAIL pixel tag=%0d got co=%h ncol=%b brit=%b sdo=%0d want co=%h ncol=%b brit=%b sdo=%0d",
                     mon_tag, CO, NCOL, BRIT, SDO, mon_e[14:4], mon_e[3], mon_e[2], mon_e[1:0]);
          end
        end
      end else if (cyc <= NL) begin
        chk_reset_outs("post_release");
      end
    end
  end

  initial begin
    nRESET = 1'b0; nCS = 1'b1; ADDR = '0; DIN = '0; CI = '0; PR = '0; SDI = '0;
    model_reset();
    clear_px();
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outs("reset_state");
    nRESET = 1'b1;

    // two opaque layers, lower priority value wins
    px_ci[0] = 9'h012; px_ci[1] = 9'h034; px_pr[0] = 6'd10; px_pr[1] = 6'd5;
    send(1'b1);
    // equal priorities: lower index wins
    px_pr[0] = 6'd7; px_pr[1] = 6'd7;
    send(1'b1);

    // transparency modes
    clear_px();
    px_ci[0] = 9'h100; send(1'b1);
    px_ci[0] = 9'h010; send(1'b1);
    write_reg(16, 8'h01);
    px_ci[0] = 9'h010; send(1'b1);
    px_ci[0] = 9'h100; send(1'b1);
    clear_px(); send(1'b1);

    // brightness and shadow thresholds
    write_reg(18, 8'd8);
    px_ci[0] = 9'h001; px_pr[0] = 6'd7; send(1'b1);
    px_pr[0] = 6'd8; send(1'b1);
    write_reg(21, 8'd20);
    px_sdi = 2'd2; px_pr[0] = 6'd19; send(1'b1);
    px_pr[0] = 6'd20; send(1'b1);
    px_sdi = 2'd0; px_pr[0] = 6'd0; send(1'b1);

    // register-selected priority and bank, then layer disable
    write_reg(17, 8'h02);
    write_reg(1, 8'd0);
    write_reg(9, 8'd3);
    clear_px();
    px_ci[0] = 9'h012; px_pr[0] = 6'd10; px_ci[1] = 9'h045; px_pr[1] = 6'd63;
    send(1'b1);
    write_reg(19, 8'h1d);
    send(1'b1);
    write_reg(19, 8'h1f);

    // asynchronous reset in the middle of a stream
    for (int n = 0; n < 8; n++) begin
      rand_px(); send(1'b1);
    end
    #2;
    nRESET = 1'b0;
    #1;
    chk_reset_outs("async_reset");
    exp_q.delete(); tag_q.delete();
    model_reset();
    @(posedge CLK);
    #1;
    chk_reset_outs("reset_hold");
    nRESET = 1'b1;
    clear_px();
    px_ci[0] = 9'h012; px_ci[1] = 9'h034; px_pr[0] = 6'd10; px_pr[1] = 6'd5;
    send(1'b1);

    // random register sets and pixels
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 10; w++) write_reg($urandom_range(0, 31), 8'($urandom));
      for (int n = 0; n < 40; n++) begin
        rand_px(); send(1'b1);
      end
    end

    // drain with a bounded wait
    for (int n = 0; n < NL + 6 && tag_q.size() != 0; n++) @(posedge CLK);
    #1;
    checks++;
    if (tag_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending results want 0", tag_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
